// File: rtl/seq_detector_pkg.sv
// Shared defaults and helpers for the serial sync-word detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_detector_pkg;

  // Default sync word: 12 bits, MSB is the first bit on the wire.
  localparam int          SEQ_PAT_W_DEF   = 12;
  localparam logic [11:0] SEQ_PATTERN_DEF = 12'b1110_1101_1011;

  // The fill counter must hold 0..w inclusive.
  function automatic int seq_fill_w(input int w);
    return $clog2(w + 1);
  endfunction

  // Fill counter type for the default pattern length.
  typedef logic [$clog2(SEQ_PAT_W_DEF + 1)-1:0] seq_fill_t;

endpackage

// File: rtl/seq_shift_reg.sv
// Bit history shift register plus saturating fill counter for seq_detector.
// Latency: q and the fill count update on the edge that samples d.
// Backpressure: none; one bit is accepted on every clock.
//
// Ports:
//   clk   in   clock, all state updates on the rising edge
//   reset in   synchronous active-high reset; clears history and fill count
//   d     in   serial bit, shifted in at the LSB every edge
//   clr   in   restart the fill count at 0 on this edge (history still shifts)
//   q     out  last W sampled bits, newest at LSB
//   full  out  high when the bit sampled on the coming edge completes a
//              window of W bits counted since reset / the last clr
module seq_shift_reg
  import seq_detector_pkg::*;
#(
  parameter int W = SEQ_PAT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         d,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         full
);

  localparam int FW = seq_fill_w(W);
  typedef logic [FW-1:0] fill_t;

  localparam fill_t FILL_MAX  = fill_t'(W);
  localparam fill_t FILL_LAST = fill_t'(W - 1);

  fill_t fill;

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      fill <= '0;
    end else begin
      q <= {q[W-2:0], d};
      if (clr) begin
        fill <= '0;
      end else if (fill != FILL_MAX) begin
        fill <= fill + 1'b1;
      end
    end
  end

  // Look-ahead flag: the top registers det_o from the next-state history, so
  // it needs to know whether the fill count will reach W on this edge.
  // That is the case once W-1 bits are already in (or the counter is full).
  assign full = (fill >= FILL_LAST);

endmodule

// File: rtl/seq_detector.sv
// Serial bit-stream sync-word detector: one-cycle det_o pulse per match of
// the last PAT_W sampled bits against PATTERN (MSB = first bit received).
// Latency: det_o rises on the edge that samples the final pattern bit.
// Backpressure: none; one bit per clock, no bubbles.
//
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   synchronous active-high reset; discards any partial match
//   x_i    in   serial data bit, sampled every rising edge
//   det_o  out  registered match flag
//
// Build option: define SEQ_DET_NONOVERLAP_EN for non-overlapping detection
// (after a match, the next one needs PAT_W fresh bits). Default: overlapping.
// PAT_W must lie in 2..32.
module seq_detector
  import seq_detector_pkg::*;
#(
  parameter int               PAT_W   = SEQ_PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(SEQ_PATTERN_DEF)
) (
  input  logic clk,
  input  logic reset,
  input  logic x_i,
  output logic det_o
);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_nxt;
  logic             full;
  logic             match_nxt;
  logic             clr;

  seq_shift_reg #(
    .W (PAT_W)
  ) u_shift (
    .clk   (clk),
    .reset (reset),
    .d     (x_i),
    .clr   (clr),
    .q     (hist),
    .full  (full)
  );

  // History as it will be after this edge; the oldest bit falls off the top.
  assign hist_nxt  = PAT_W'({hist, x_i});

  // Gating on the fill count keeps reset zeros from aliasing a pattern that
  // starts with zeros.
  assign match_nxt = full && (hist_nxt == PATTERN);

`ifdef SEQ_DET_NONOVERLAP_EN
  // Restart the fill count on the matching edge itself, so the very next
  // sampled bit is the first of the PAT_W fresh bits the next match needs.
  assign clr = match_nxt;
`else
  assign clr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      det_o <= 1'b0;
    end else begin
      det_o <= match_nxt;
    end
  end

endmodule

// File: tb/tb_seq_detector.sv
module tb_seq_detector;

  logic clk = 1'b0;
  logic reset;
  logic xa, xb, xc;
  logic deta, detb, detc;

  always #5 clk = ~clk;

  // Default 12-bit sync word.
  seq_detector u_a (
    .clk   (clk),
    .reset (reset),
    .x_i   (xa),
    .det_o (deta)
  );

  // All-zero pattern: exercises fill gating.
  seq_detector #(.PAT_W(4), .PATTERN(4'b0000)) u_b (
    .clk   (clk),
    .reset (reset),
    .x_i   (xb),
    .det_o (detb)
  );

  // Self-overlapping pattern: distinguishes overlap / non-overlap modes.
  seq_detector #(.PAT_W(4), .PATTERN(4'b1010)) u_c (
    .clk   (clk),
    .reset (reset),
    .x_i   (xc),
    .det_o (detc)
  );

  typedef struct {
    int    inst;
    logic  exp;
    string tag;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  pulses_a = 0;

  logic [11:0] pat   = 12'b1110_1101_1011;
  logic [11:0] near1 = 12'b1110_1101_1010;
  logic [11:0] near2 = 12'b0110_1101_1011;
  logic [9:0]  t5bits = 10'b1010101010;

  // Pop one scoreboard entry and compare it against the addressed instance.
  task automatic check_out();
    sb_t  e;
    logic obs;
    e   = sb_q.pop_front();
    obs = (e.inst == 0) ? deta : ((e.inst == 1) ? detb : detc);
    if (e.inst == 0 && obs === 1'b1) pulses_a++;
    n_checks++;
    assert (obs === e.exp) else begin
      n_errors++;
      $error("FAIL %s inst=%0d observed=%b expected=%b", e.tag, e.inst, obs, e.exp);
    end
  endtask

  // Push an expectation and check it right away (no clock).
  task automatic chk(input int inst, input logic exp, input string tag);
    sb_t e;
    e.inst = inst;
    e.exp  = exp;
    e.tag  = tag;
    sb_q.push_back(e);
    check_out();
  endtask

  // Drive reset and one bit on the negedge, expect det after the next posedge.
  task automatic cyc(input int inst, input logic r, input logic b,
                     input logic exp, input string tag);
    sb_t e;
    @(negedge clk);
    reset = r;
    case (inst)
      0:       xa = b;
      1:       xb = b;
      default: xc = b;
    endcase
    e.inst = inst;
    e.exp  = exp;
    e.tag  = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    logic [11:0] m_hist;
    int          m_fresh;
    logic        r, b, e;

    reset = 1'b1;
    xa = 1'b0;
    xb = 1'b0;
    xc = 1'b0;

    // Reset state on all instances; bits sampled during reset are ignored.
    cyc(0, 1'b1, 1'b0, 1'b0, "reset_a");
    chk(1, 1'b0, "reset_b");
    chk(2, 1'b0, "reset_c");
    cyc(0, 1'b1, 1'b1, 1'b0, "reset_bit_ignored");

    // T1: three back-to-back repetitions, pulse after bits 12, 24, 36.
    pulses_a = 0;
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 11; i >= 0; i--) begin
        cyc(0, 1'b0, pat[i], (i == 0), "t1_repeat");
      end
    end
    n_checks++;
    assert (pulses_a == 3) else begin
      n_errors++;
      $error("FAIL t1_pulse_count observed=%0d expected=3", pulses_a);
    end

    // T2: 11-bit partial, reset pulse, lone 1, then the full pattern.
    cyc(0, 1'b1, 1'b0, 1'b0, "t2_reset");
    for (int i = 11; i >= 1; i--) begin
      cyc(0, 1'b0, pat[i], 1'b0, "t2_partial");
    end
    cyc(0, 1'b1, 1'b1, 1'b0, "t2_mid_reset");
    cyc(0, 1'b0, 1'b1, 1'b0, "t2_after_reset");
    pulses_a = 0;
    for (int i = 11; i >= 0; i--) begin
      cyc(0, 1'b0, pat[i], (i == 0), "t2_full");
    end
    n_checks++;
    assert (pulses_a == 1) else begin
      n_errors++;
      $error("FAIL t2_pulse_count observed=%0d expected=1", pulses_a);
    end

    // T3: near misses never fire; a 1-prefix plus pattern fires once.
    cyc(0, 1'b1, 1'b0, 1'b0, "t3_reset");
    for (int i = 11; i >= 0; i--) cyc(0, 1'b0, near1[i], 1'b0, "t3_near1");
    for (int i = 11; i >= 0; i--) cyc(0, 1'b0, near2[i], 1'b0, "t3_near2");
    cyc(0, 1'b0, 1'b1, 1'b0, "t3_prefix");
    for (int i = 11; i >= 0; i--) begin
      cyc(0, 1'b0, pat[i], (i == 0), "t3_pattern");
    end

    // T4: all-zero pattern, zeros from reset release.
    cyc(1, 1'b1, 1'b0, 1'b0, "t4_reset");
    for (int n = 1; n <= 9; n++) begin
`ifdef SEQ_DET_NONOVERLAP_EN
      cyc(1, 1'b0, 1'b0, (n % 4 == 0), "t4_fill_gate");
`else
      cyc(1, 1'b0, 1'b0, (n >= 4), "t4_fill_gate");
`endif
    end

    // T5: 1010101010 against 4'b1010.
    cyc(2, 1'b1, 1'b0, 1'b0, "t5_reset");
    for (int n = 1; n <= 10; n++) begin
`ifdef SEQ_DET_NONOVERLAP_EN
      cyc(2, 1'b0, t5bits[10-n], (n == 4 || n == 8), "t5_nonoverlap");
`else
      cyc(2, 1'b0, t5bits[10-n], (n >= 4 && n % 2 == 0), "t5_overlap");
`endif
    end

    // T6: random stream with occasional resets against a reference model that
    // counts bits sampled since reset (or since the last match when
    // non-overlapping) and compares the last 12 bits.
    cyc(0, 1'b1, 1'b0, 1'b0, "t6_reset");
    m_hist  = '0;
    m_fresh = 0;
    for (int k = 0; k < 10000; k++) begin
      r = ($urandom_range(0, 299) == 0);
      b = 1'($urandom_range(0, 1));
      if (r) begin
        m_hist  = '0;
        m_fresh = 0;
        e       = 1'b0;
      end else begin
        m_hist = {m_hist[10:0], b};
        if (m_fresh < 64) m_fresh++;
        e = (m_fresh >= 12) && (m_hist == pat);
`ifdef SEQ_DET_NONOVERLAP_EN
        if (e) m_fresh = 0;
`endif
      end
      cyc(0, r, b, e, "t6_random");
    end

    n_checks++;
    assert (sb_q.size() == 0) else begin
      n_errors++;
      $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
